// File: rtl/incubator_pkg.sv
// Shared types and constants for the incubator sensor scheduler.
// Optional INCUBATOR_SENSOR_CLAMP_EN adds a sample saturation helper.
package incubator_pkg;

  localparam int TEMP_W = 8;

  localparam logic signed [TEMP_W-1:0] SAFE_T    = 8'sd25;
  localparam logic signed [TEMP_W-1:0] CLAMP_MIN = -8'sd20;
  localparam logic signed [TEMP_W-1:0] CLAMP_MAX = 8'sd60;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_REQ    = 3'd2,
    ST_UPDATE = 3'd3,
    ST_FAULT  = 3'd4
  } sched_state_e;

`ifdef INCUBATOR_SENSOR_CLAMP_EN
  function automatic logic signed [TEMP_W-1:0] clamp_temp(input logic signed [TEMP_W-1:0] v);
    if (v < CLAMP_MIN) return CLAMP_MIN;
    if (v > CLAMP_MAX) return CLAMP_MAX;
    return v;
  endfunction
`endif

endpackage

// File: rtl/incubator_avg_window.sv
// Moving-average window: shift register of samples, preload on first sample,
// signed sum and arithmetic shift into a registered temperature output.
module incubator_avg_window
  import incubator_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [TEMP_W-1:0] sample,
  input  logic                     push,
  input  logic                     preload,
  output logic signed [TEMP_W-1:0] t
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = TEMP_W + AVG_LOG2;

  logic signed [TEMP_W-1:0] win_q [DEPTH];
  logic signed [TEMP_W-1:0] win_d [DEPTH];
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [TEMP_W-1:0] t_q, t_d;

  always_comb begin
    win_d = win_q;
    sum_d = '0;
    t_d   = t_q;
    if (push) begin
      win_d[0] = sample;
      for (int i = 1; i < DEPTH; i++) begin
        win_d[i] = preload ? sample : win_q[i-1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      sum_d = sum_d + SUM_W'(win_d[i]);
    end
    // Arithmetic shift floors toward -inf; result always fits TEMP_W.
    if (push) t_d = TEMP_W'(sum_d >>> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      t_q <= SAFE_T;
    end else begin
      win_q <= win_d;
      t_q   <= t_d;
    end
  end

  assign t = t_q;

endmodule

// File: rtl/incubator_sensor_scheduler.sv
// Periodic sensor read sequencer with timeout fault and moving-average output.
// Define INCUBATOR_SENSOR_CLAMP_EN to saturate captured samples to [-20, 60].
//
// state  | meaning
// IDLE   | sampling disabled, window retained
// WAIT   | period timer counting down to next read
// REQ    | sensor_req high, timeout timer counting down
// UPDATE | captured sample pushed into window, T updated next edge
// FAULT  | sensor did not answer; sticky until clear_fault
module incubator_sensor_scheduler
  import incubator_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 100,
  parameter int TIMEOUT       = 16,
  parameter int AVG_LOG2      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear_fault,
  input  logic                     sensor_ack,
  input  logic signed [TEMP_W-1:0] sensor_data,
  output logic                     sensor_req,
  output logic signed [TEMP_W-1:0] T,
  output logic                     t_valid,
  output logic                     fault
);

  localparam int TMR_MAX = (SAMPLE_PERIOD > TIMEOUT) ? SAMPLE_PERIOD : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PERIOD_LD = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [TMR_W-1:0] TO_LD     = TMR_W'(TIMEOUT - 1);

  sched_state_e             state_q, state_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic signed [TEMP_W-1:0] sample_q, sample_d;
  logic                     empty_q, empty_d;
  logic                     t_valid_q, t_valid_d;
  logic signed [TEMP_W-1:0] sample_in;
  logic                     push, preload;

`ifdef INCUBATOR_SENSOR_CLAMP_EN
  assign sample_in = clamp_temp(sensor_data);
`else
  assign sample_in = sensor_data;
`endif

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    sample_d  = sample_q;
    empty_d   = empty_q;
    push      = 1'b0;
    preload   = 1'b0;
    t_valid_d = (state_q == ST_UPDATE);
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT;
          tmr_d   = PERIOD_LD;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          state_d = ST_REQ;
          tmr_d   = TO_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_REQ: begin
        // Ack is checked before terminal count so a last-cycle ack wins.
        if (sensor_ack) begin
          sample_d = sample_in;
          state_d  = ST_UPDATE;
        end else if (tmr_q == '0) begin
          state_d = ST_FAULT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_UPDATE: begin
        push    = 1'b1;
        preload = empty_q;
        empty_d = 1'b0;
        if (enable) begin
          state_d = ST_WAIT;
          tmr_d   = PERIOD_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d = ST_IDLE;
          empty_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      sample_q  <= '0;
      empty_q   <= 1'b1;
      t_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      sample_q  <= sample_d;
      empty_q   <= empty_d;
      t_valid_q <= t_valid_d;
    end
  end

  incubator_avg_window #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg_window (
    .clk    (clk),
    .reset  (reset),
    .sample (sample_q),
    .push   (push),
    .preload(preload),
    .t      (T)
  );

  assign sensor_req = (state_q == ST_REQ);
  assign fault      = (state_q == ST_FAULT);
  assign t_valid    = t_valid_q;

endmodule

// File: tb/tb_incubator_sensor_scheduler.sv
// Directed self-checking bench for incubator_sensor_scheduler
// (SAMPLE_PERIOD=8, TIMEOUT=4, AVG_LOG2=2).
module tb_incubator_sensor_scheduler;

  localparam int P  = 8;
  localparam int TO = 4;
  localparam int L  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              clear_fault;
  logic              sensor_ack;
  logic signed [7:0] sensor_data;
  logic              sensor_req;
  logic signed [7:0] T;
  logic              t_valid;
  logic              fault;

  int checks   = 0;
  int failures = 0;

  incubator_sensor_scheduler #(
    .SAMPLE_PERIOD(P),
    .TIMEOUT      (TO),
    .AVG_LOG2     (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear_fault(clear_fault),
    .sensor_ack (sensor_ack),
    .sensor_data(sensor_data),
    .sensor_req (sensor_req),
    .T          (T),
    .t_valid    (t_valid),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (!sensor_req && n < limit) begin
      tick();
      n++;
    end
    if (!sensor_req) check("req_wait_timeout", 0, 1);
  endtask

  task automatic do_sample(input string tag, input int data, input int exp_t);
    int n;
    wait_req(40, n);
    sensor_data = 8'(data);
    sensor_ack  = 1'b1;
    tick();
    sensor_ack  = 1'b0;
    check({tag, "_req_drop"}, int'(sensor_req), 0);
    check({tag, "_tv_early"}, int'(t_valid), 0);
    tick();
    check({tag, "_tv"}, int'(t_valid), 1);
    check({tag, "_T"}, int'(T), exp_t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int req_seen;
    reset       = 1'b1;
    enable      = 1'b0;
    clear_fault = 1'b0;
    sensor_ack  = 1'b0;
    sensor_data = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_req", int'(sensor_req), 0);
    check("rst_T", int'(T), 25);
    check("rst_tv", int'(t_valid), 0);
    check("rst_fault", int'(fault), 0);

    // 1: reset while in REQ
    enable = 1'b1;
    wait_req(40, n);
    check("t1_req_up", int'(sensor_req), 1);
    reset = 1'b1;
    tick();
    check("t1_req", int'(sensor_req), 0);
    check("t1_T", int'(T), 25);
    check("t1_tv", int'(t_valid), 0);
    check("t1_fault", int'(fault), 0);
    reset  = 1'b0;
    enable = 1'b0;
    tick();

    // 2: first sample preloads; period timing
    enable = 1'b1;
    wait_req(40, n);
    check("t2_first_req_lat", n, 9);
    do_sample("t2_s40", 40, 40);
    tick();
    check("t2_tv_pulse_end", int'(t_valid), 0);
    wait_req(40, n);
    check("t2_period", n, 7);

    // 3: shift in 20 then -3
    do_sample("t3_s20", 20, 35);
    do_sample("t3_sm3", -3, 24);

    // 4: negative samples with floor
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_sample("t4_sm5", -5, -5);
    do_sample("t4_sm6", -6, -6);

    // 5a: timeout -> fault
    wait_req(40, n);
    tick();
    tick();
    tick();
    check("t5_req_c4", int'(sensor_req), 1);
    check("t5_nofault_c4", int'(fault), 0);
    tick();
    check("t5_fault", int'(fault), 1);
    check("t5_req_off", int'(sensor_req), 0);
    check("t5_T_hold", int'(T), -6);
    sensor_data = 8'sd99;
    sensor_ack  = 1'b1;
    tick();
    sensor_ack  = 1'b0;
    tick();
    check("t5_ack_ignored_tv", int'(t_valid), 0);
    check("t5_ack_ignored_T", int'(T), -6);
    check("t5_fault_sticky", int'(fault), 1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("t5_fault_clr", int'(fault), 0);
    do_sample("t5_s30", 30, 30);

    // 5b: ack on last allowed cycle
    wait_req(40, n);
    tick();
    tick();
    tick();
    check("t5b_req_c4", int'(sensor_req), 1);
    sensor_data = 8'sd50;
    sensor_ack  = 1'b1;
    tick();
    sensor_ack  = 1'b0;
    check("t5b_nofault", int'(fault), 0);
    check("t5b_req_off", int'(sensor_req), 0);
    tick();
    check("t5b_tv", int'(t_valid), 1);
    check("t5b_T", int'(T), 35);

    // 6: enable drop during REQ
    wait_req(40, n);
    enable = 1'b0;
    tick();
    check("t6_req_held", int'(sensor_req), 1);
    sensor_data = 8'sd2;
    sensor_ack  = 1'b1;
    tick();
    sensor_ack  = 1'b0;
    tick();
    check("t6_tv", int'(t_valid), 1);
    check("t6_T", int'(T), 28);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sensor_req) req_seen++;
    end
    check("t6_no_req", req_seen, 0);

    // clamp build option: out-of-range first sample
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    enable = 1'b1;
`ifdef INCUBATOR_SENSOR_CLAMP_EN
    do_sample("t6_s100", 100, 60);
`else
    do_sample("t6_s100", 100, 100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/incubator_sensor_scheduler.md
Name: incubator_sensor_scheduler

Overview:
Sequences the shared temperature sensor that feeds the Incubator controller. Issues a periodic read request over a req/ack handshake and maintains a 2^AVG_LOG2-sample moving average. Drives the filtered signed temperature T, with a one-cycle valid strobe, into the heater/cooler FSM. Detects a non-responding sensor and holds a sticky fault until cleared.

Parameters:
SAMPLE_PERIOD, 100, number of idle cycles in WAIT between reads (>=2)
TIMEOUT, 16, maximum cycles sensor_req may stay high without ack (>=1)
AVG_LOG2, 2, log2 of averaging window depth (window = 4 by default)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run periodic sampling when high
clear_fault  in  1  leave FAULT state (level, sampled in FAULT only)
sensor_ack  in  1  sensor data valid; honoured only while sensor_req=1
sensor_data  in  8  signed raw temperature, captured on the ack cycle
sensor_req  out  1  read request to sensor, held until ack or timeout
T  out  8  signed filtered temperature to Incubator
t_valid  out  1  one-cycle pulse when T updates
fault  out  1  sticky sensor-timeout flag

Behaviour:
- Reset (synchronous, active-high, checked on clk edge, overrides everything): state=IDLE, sensor_req=0, T=8'sd25 (SAFE_T, inside the Incubator idle band), t_valid=0, fault=0, timers=0, window marked empty. Reset mid-handshake drops sensor_req on the same edge.
- States: IDLE, WAIT, REQ, UPDATE, FAULT.
- IDLE: enable=1 -> WAIT, period timer loaded with SAMPLE_PERIOD-1.
- WAIT: timer decrements each cycle. At 0 -> REQ, with sensor_req=1 from the next cycle. enable=0 in WAIT -> IDLE immediately.
- REQ: sensor_req=1; timeout counter counts req-high cycles starting at 1.
  - sensor_ack=1 -> capture sensor_data, sensor_req=0 on that edge, -> UPDATE.
  - No ack by the end of the TIMEOUT-th req-high cycle -> FAULT, sensor_req=0, fault=1.
  - Ack in the TIMEOUT-th cycle is accepted; ack wins over timeout.
  - enable dropping in REQ does not abort; completion or fault still occurs.
- UPDATE (1 cycle):
  - If window empty: every entry is preloaded with the captured sample.
  - Otherwise: shift the new sample in and drop the oldest.
  - Sum is signed, 8+AVG_LOG2 bits, no overflow possible.
  - T <= sum >>> AVG_LOG2 (arithmetic shift, floor toward -inf).
  - t_valid=1 for exactly the cycle after UPDATE. Next state is WAIT (reload SAMPLE_PERIOD-1) if enable=1, else IDLE.
- Latency: ack sampled at edge k -> T and t_valid visible after edge k+1. Sample-to-sample interval = SAMPLE_PERIOD + req cycles + 1.
- sensor_ack outside REQ is ignored.
- FAULT: T holds its last value, sensor_req=0, fault=1. clear_fault=1 -> IDLE, fault=0, window marked empty, so the next sample preloads.
- The window is retained across IDLE. Only reset or a fault clear empties it.

Optional Feature:
INCUBATOR_SENSOR_CLAMP_EN
- Defined: the captured sample is saturated to [-20, 60] before entering the window, rejecting sensor glitches.
- Undefined: the raw sample is used unchanged, with no clamp logic.

Decomposition:
- Package incubator_pkg holds:
  - state enum
  - TEMP_W=8
  - SAFE_T=25
  - CLAMP_MIN=-20, CLAMP_MAX=60
- Sub-module incubator_avg_window: shift-register window, preload, signed sum and shift.
- Output: T. Inputs: sample, push, preload.

Test Plan (SAMPLE_PERIOD=8, TIMEOUT=4, AVG_LOG2=2):
1. Assert reset mid-REQ -> next cycle sensor_req=0, T=25, t_valid=0, fault=0.
2. enable=1, first ack with data 40 -> window preloaded; T=40 with one t_valid pulse one cycle after UPDATE. Next sensor_req rises 8 cycles after WAIT entry.
3. Samples 20 then -3 after the 40 preload -> T=35 (sum 140), then T=24 (sum 97, floor).
4. After reset, all samples -5 then -6 -> T=-5, then T=-6 (sum -21 >>> 2, floor toward -inf).
5. Timeout handling:
   - Withhold ack for 4 req cycles -> fault=1, sensor_req=0, T held.
   - Ack on cycle 4 in another run -> accepted, no fault.
   - clear_fault -> IDLE; next sample 30 preloads and gives T=30.
6. Drop enable during REQ -> handshake completes, T updates, state becomes IDLE, no further sensor_req. With INCUBATOR_SENSOR_CLAMP_EN, data 100 on first sample -> T=60.
